ct_f_spsram_256x144_ctrl: RTL

Initiator-side access controller for the 256x144 single-port FPGA SRAM macro. It converts a valid/ready request stream into the macro's active-low pin protocol (A, CEN, GWEN, WEN, D) and captures Q into a buffered valid/ready response stream. After reset it clears the whole array once, before any request is accepted. It sits between the cache/TLB array logic and the SRAM macro.

---
 rtl/ct_f_spsram_ctrl_pkg.sv | 14 +
 rtl/ct_f_spsram_rsp_fifo.sv | 52 +++++
 rtl/ct_f_spsram_256x144_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared encodings for the single-port SRAM array controllers.
// Pin constants are the idle (inactive) levels of the active-low macro pins.
package ct_f_spsram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic CEN_IDLE  = 1'b1;
    localparam logic GWEN_READ = 1'b1;
    localparam logic WEN_NONE  = 1'b1;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// DEPTH x DATA_WIDTH synchronous FIFO with show-ahead head output.
// Push while full is accepted only together with a pop.
module ct_f_spsram_rsp_fifo #(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 144
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= nxt(wptr_q);
            end
            if (do_pop) rptr_q <= nxt(rptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ct_f_spsram_256x144_ctrl.sv
// Request/response controller for the 256x144 single-port SRAM macro,
// with a one-time clearing sweep of the array after reset.
module ct_f_spsram_256x144_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 144,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int                    RSP_DEPTH  = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int OW    = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);
    localparam state_e RST_ST = INIT_EN ? ST_INIT : ST_RUN;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic                  rdy_q, rdy_d;
    logic                  rd_pend_q;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  acc, rd_acc;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign acc    = (state_q == ST_RUN) & req_vld & rdy_q;
    assign rd_acc = acc & ~req_wr;

    assign rsp_vld   = ~fifo_empty;
    assign fifo_pop  = rsp_vld & rsp_rdy;
    assign fifo_push = rd_pend_q & (~fifo_full | fifo_pop);

    assign req_rdy   = rdy_q;
    assign init_busy = (state_q == ST_INIT);
    assign init_done = (state_q == ST_RUN);
    assign sram_a    = a_d;
    assign sram_d    = d_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        d_d       = d_q;
        sram_cen  = CEN_IDLE;
        sram_gwen = GWEN_READ;
        sram_wen  = {DATA_WIDTH{WEN_NONE}};
        unique case (state_q)
            ST_INIT: begin
                cnt_d     = cnt_q + 1'b1;
                a_d       = cnt_q;
                d_d       = INIT_VAL;
                sram_cen  = ~CEN_IDLE;
                sram_gwen = ~GWEN_READ;
                sram_wen  = ~{DATA_WIDTH{WEN_NONE}};
                if (cnt_q == LAST_A) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (acc) begin
                    a_d       = req_addr;
                    d_d       = req_wdata;
                    sram_cen  = ~CEN_IDLE;
                    sram_gwen = ~req_wr;
                    sram_wen  = ~req_bmask;
                end
            end
            default: state_d = RST_ST;
        endcase
        // The macro must never see a selected cycle while reset is held.
        if (cpurst) begin
            sram_cen  = CEN_IDLE;
            sram_gwen = GWEN_READ;
            sram_wen  = {DATA_WIDTH{WEN_NONE}};
        end
    end

    always_comb begin
        outst_d = outst_q + OW'(rd_acc) - OW'(fifo_pop);
        rdy_d   = (state_d == ST_RUN) && (outst_d < OW'(RSP_DEPTH));
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q   <= RST_ST;
            cnt_q     <= '0;
            outst_q   <= '0;
            rdy_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            outst_q   <= outst_d;
            rdy_q     <= rdy_d;
            rd_pend_q <= rd_acc;
            a_q       <= a_d;
            d_q       <= d_d;
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk     (forever_cpuclk),
        .rst     (cpurst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (sram_q),
        .rdata_o (rsp_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
